mem_burst_axi_master: RTL and testbench

//  Downstream of the burst test generator: converts its rd/wr burst request interface into AXI4 INCR bursts

---
 rtl/mem_burst_pkg.sv | 25 ++
 rtl/mem_burst_axi_master_if.sv | 64 ++++++
 rtl/mem_burst_wskid.sv | 45 ++++
 rtl/mem_burst_axi_master.sv | 157 +++++++++++++++
 tb/tb_mem_burst_axi_master.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_burst_pkg.sv
// Shared constants and FSM encoding for the burst-to-AXI4 master.
// Optional build macro: AXI_RESP_CHECK_EN (sticky AXI response error flag).
package mem_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_FIN
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int BEAT_BYTES = 8;
  localparam int BEAT_SIZE  = $clog2(BEAT_BYTES);

  function automatic int beat_size(input int data_bits);
    return $clog2(data_bits / 8);
  endfunction

endpackage

// File: rtl/mem_burst_axi_master_if.sv
// AXI4 read/write channel bundle between the burst master and the HP port.
// Optional build macro: AXI_RESP_CHECK_EN (uses bresp/rresp).
interface mem_burst_axi_master_if #(
  parameter int DATA_BITS = 64,
  parameter int ADDR_BITS = 32
);

  logic [ADDR_BITS-1:0]   awaddr;
  logic [7:0]             awlen;
  logic [2:0]             awsize;
  logic [1:0]             awburst;
  logic                   awvalid;
  logic                   awready;

  logic [DATA_BITS-1:0]   wdata;
  logic [DATA_BITS/8-1:0] wstrb;
  logic                   wlast;
  logic                   wvalid;
  logic                   wready;

  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;

  logic [ADDR_BITS-1:0]   araddr;
  logic [7:0]             arlen;
  logic [2:0]             arsize;
  logic [1:0]             arburst;
  logic                   arvalid;
  logic                   arready;

  logic [DATA_BITS-1:0]   rdata;
  logic [1:0]             rresp;
  logic                   rlast;
  logic                   rvalid;
  logic                   rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/mem_burst_wskid.sv
// Two-entry FIFO decoupling user write data from the AXI W channel.
// Optional build macro: none.
module mem_burst_wskid #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;
  logic         do_push;
  logic         do_pop;

  assign full    = count == 2'd2;
  assign empty   = count == 2'd0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) wp <= ~wp;
      if (do_pop)  rp <= ~rp;
      count <= 2'(count + 2'(do_push) - 2'(do_pop));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/mem_burst_axi_master.sv
// Converts user rd/wr burst requests into single-outstanding AXI4 INCR bursts.
// Optional build macro: AXI_RESP_CHECK_EN (sticky axi_error on non-OKAY resp).
module mem_burst_axi_master
  import mem_burst_pkg::*;
#(
  parameter int MEM_DATA_BITS = BEAT_BYTES * 8,
  parameter int ADDR_BITS     = 32,
  parameter int MAX_BURST_LEN = 256
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic                     wr_burst_req,
  input  logic [9:0]               wr_burst_len,
  input  logic [ADDR_BITS-1:0]     wr_burst_addr,
  output logic                     wr_burst_data_req,
  input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
  output logic                     wr_burst_finish,
  input  logic                     rd_burst_req,
  input  logic [9:0]               rd_burst_len,
  input  logic [ADDR_BITS-1:0]     rd_burst_addr,
  output logic                     rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0] rd_burst_data,
  output logic                     rd_burst_finish,
  output logic                     axi_error,
  mem_burst_axi_master_if.master   m_axi
);

  localparam int BB = MEM_DATA_BITS / 8;
  localparam logic [2:0] SZ = 3'(beat_size(MEM_DATA_BITS));
  localparam logic [9:0] MAXL = 10'(MAX_BURST_LEN);
  localparam logic [ADDR_BITS-1:0] AMASK = ~ADDR_BITS'(BB - 1);

  state_t st, st_nx;
  logic                 is_wr, last_wr;
  logic [ADDR_BITS-1:0] addr_q;
  logic [9:0]           len_q, req_cnt, wcnt, wcnt_nx;
  logic                 pend;

  logic                 sel_wr, acc;
  logic [9:0]           raw_len, req_len;
  logic                 w_act, w_full, w_empty, pop;
  logic [1:0]           w_cnt;
  logic [2:0]           fill, room;

  // Write wins a tie unless it was the last one served.
  assign sel_wr  = wr_burst_req & (~rd_burst_req | ~last_wr);
  assign acc     = (st == ST_IDLE) & (wr_burst_req | rd_burst_req);
  assign raw_len = sel_wr ? wr_burst_len : rd_burst_len;
  assign req_len = (raw_len > MAXL) ? MAXL : raw_len;

  assign w_act   = (st == ST_WR_ADDR) | (st == ST_WR_DATA);
  assign pop     = m_axi.wvalid & m_axi.wready;
  assign wcnt_nx = wcnt + 10'(pop);

  // Beats already buffered or in flight must leave room for this request.
  assign fill = 3'(w_cnt) + 3'(pend);
  assign room = 3'd1 + 3'(pop);
  assign wr_burst_data_req = w_act & (req_cnt < len_q) &
                             (fill <= room) & ~(w_full & ~pop);

  mem_burst_wskid #(.W(MEM_DATA_BITS)) u_wskid (
    .clk   (mem_clk),
    .rst   (rst),
    .push  (pend),
    .din   (wr_burst_data),
    .pop   (pop),
    .dout  (m_axi.wdata),
    .full  (w_full),
    .empty (w_empty),
    .count (w_cnt)
  );

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = 8'(len_q - 10'd1);
  assign m_axi.awsize  = SZ;
  assign m_axi.awburst = AXI_BURST_INCR;
  assign m_axi.awvalid = st == ST_WR_ADDR;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = wcnt == (len_q - 10'd1);
  assign m_axi.wvalid  = w_act & ~w_empty;
  assign m_axi.bready  = st == ST_WR_RESP;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = 8'(len_q - 10'd1);
  assign m_axi.arsize  = SZ;
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.arvalid = st == ST_RD_ADDR;
  assign m_axi.rready  = st == ST_RD_DATA;

  assign rd_burst_data       = m_axi.rdata;
  assign rd_burst_data_valid = (st == ST_RD_DATA) & m_axi.rvalid;
  assign wr_burst_finish = ((st == ST_WR_RESP) & m_axi.bvalid) |
                           ((st == ST_FIN) & is_wr);
  assign rd_burst_finish = (rd_burst_data_valid & m_axi.rlast) |
                           ((st == ST_FIN) & ~is_wr);

  always_comb begin
    st_nx = st;
    unique case (st)
      ST_IDLE: begin
        if (acc) begin
          if (req_len == 10'd0) st_nx = ST_FIN;
          else if (sel_wr)      st_nx = ST_WR_ADDR;
          else                  st_nx = ST_RD_ADDR;
        end
      end
      ST_WR_ADDR: if (m_axi.awready) st_nx = ST_WR_DATA;
      ST_WR_DATA: if (wcnt_nx == len_q) st_nx = ST_WR_RESP;
      ST_WR_RESP: if (m_axi.bvalid) st_nx = ST_IDLE;
      ST_RD_ADDR: if (m_axi.arready) st_nx = ST_RD_DATA;
      ST_RD_DATA: if (m_axi.rvalid & m_axi.rlast) st_nx = ST_IDLE;
      ST_FIN:     st_nx = ST_IDLE;
      default:    st_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      st      <= ST_IDLE;
      is_wr   <= 1'b0;
      last_wr <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      req_cnt <= '0;
      wcnt    <= '0;
      pend    <= 1'b0;
    end else begin
      st   <= st_nx;
      pend <= wr_burst_data_req;
      if (wr_burst_data_req) req_cnt <= req_cnt + 10'd1;
      wcnt <= wcnt_nx;
      if (acc) begin
        is_wr   <= sel_wr;
        last_wr <= sel_wr;
        addr_q  <= (sel_wr ? wr_burst_addr : rd_burst_addr) & AMASK;
        len_q   <= req_len;
        req_cnt <= '0;
        wcnt    <= '0;
      end
    end
  end

`ifdef AXI_RESP_CHECK_EN
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      axi_error <= 1'b0;
    end else if ((m_axi.bvalid & m_axi.bready &
                  (m_axi.bresp != AXI_RESP_OKAY)) |
                 (m_axi.rvalid & m_axi.rready &
                  (m_axi.rresp != AXI_RESP_OKAY))) begin
      axi_error <= 1'b1;
    end
  end
`else
  assign axi_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_burst_axi_master.sv
// Directed bench for mem_burst_axi_master with an AXI slave and burst model.
// Optional build macro: AXI_RESP_CHECK_EN (changes expected axi_error).
module tb_mem_burst_axi_master;
  import mem_burst_pkg::*;

`ifdef AXI_RESP_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        mem_clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_burst_req = 1'b0;
  logic [9:0]  wr_burst_len = '0;
  logic [31:0] wr_burst_addr = '0;
  logic        wr_burst_data_req;
  logic [63:0] wr_burst_data = '0;
  logic        wr_burst_finish;
  logic        rd_burst_req = 1'b0;
  logic [9:0]  rd_burst_len = '0;
  logic [31:0] rd_burst_addr = '0;
  logic        rd_burst_data_valid;
  logic [63:0] rd_burst_data;
  logic        rd_burst_finish;
  logic        axi_error;

  always #5 mem_clk = ~mem_clk;

  mem_burst_axi_master_if #(.DATA_BITS(64), .ADDR_BITS(32)) m_axi ();

  mem_burst_axi_master dut (
    .mem_clk             (mem_clk),
    .rst                 (rst),
    .wr_burst_req        (wr_burst_req),
    .wr_burst_len        (wr_burst_len),
    .wr_burst_addr       (wr_burst_addr),
    .wr_burst_data_req   (wr_burst_data_req),
    .wr_burst_data       (wr_burst_data),
    .wr_burst_finish     (wr_burst_finish),
    .rd_burst_req        (rd_burst_req),
    .rd_burst_len        (rd_burst_len),
    .rd_burst_addr       (rd_burst_addr),
    .rd_burst_data_valid (rd_burst_data_valid),
    .rd_burst_data       (rd_burst_data),
    .rd_burst_finish     (rd_burst_finish),
    .axi_error           (axi_error),
    .m_axi               (m_axi)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: expected burst parameters derived from the request rules.
  logic [31:0] m_wr_addr = '0, m_rd_addr = '0, cur_id = '0;
  int m_wr_len = 0, m_rd_len = 0;
  int w_idx = 0, r_idx = 0, d_i = 0;
  int aw_cnt = 0, ar_cnt = 0, dreq_cnt = 0, wfin_cnt = 0, rfin_cnt = 0;
  logic [7:0] last_awlen = '0, last_arlen = '0;
  logic [31:0] last_awaddr = '0;
  logic [7:0] fin_q[$];
  logic [7:0] m_last = "R";
  bit rand_wready = 1'b0;
  logic [1:0] bresp_cfg = 2'b00;

  function automatic logic [63:0] wpat(input logic [31:0] id, input int i);
    return {id, 32'(i)};
  endfunction

  function automatic logic [63:0] rpat(input logic [31:0] a, input int i);
    return {a ^ 32'hC0DE_0000, 32'(i)};
  endfunction

  function automatic int clamp(input int len);
    return (len > 256) ? 256 : len;
  endfunction

  // Compare process: every handshake and user-side pulse against the model.
  always @(negedge mem_clk) begin
    if (!rst) begin
      if (m_axi.awvalid && m_axi.awready) begin
        chk("awaddr", m_axi.awaddr, m_wr_addr);
        chk("awlen", m_axi.awlen, 64'(m_wr_len - 1));
        chk("awsize", m_axi.awsize, 3);
        chk("awburst", m_axi.awburst, 1);
        last_awlen = m_axi.awlen;
        last_awaddr = m_axi.awaddr;
        aw_cnt++;
      end
      if (m_axi.wvalid && m_axi.wready) begin
        chk("wdata", m_axi.wdata, wpat(cur_id, w_idx));
        chk("wlast", m_axi.wlast, w_idx == m_wr_len - 1);
        chk("wstrb", m_axi.wstrb, 8'hFF);
        w_idx++;
      end
      if (m_axi.arvalid && m_axi.arready) begin
        chk("araddr", m_axi.araddr, m_rd_addr);
        chk("arlen", m_axi.arlen, 64'(m_rd_len - 1));
        chk("arsize", m_axi.arsize, 3);
        last_arlen = m_axi.arlen;
        ar_cnt++;
      end
      if (rd_burst_data_valid) begin
        chk("rd_data", rd_burst_data, rpat(m_rd_addr, r_idx));
        chk("rd_finish_at_last", rd_burst_finish, r_idx == m_rd_len - 1);
        r_idx++;
      end
      if (wr_burst_data_req) dreq_cnt++;
      if (wr_burst_finish) begin wfin_cnt++; fin_q.push_back("W"); end
      if (rd_burst_finish) begin rfin_cnt++; fin_q.push_back("R"); end
    end
  end

  // AXI slave: readies/responses change #1 after posedge, handshakes seen at negedge.
  bit s_aw, s_wl, s_bhs, s_ract, s_rhs;
  logic [31:0] s_ra;
  int s_rn, s_ri;
  initial begin
    m_axi.awready = 1'b1;
    m_axi.arready = 1'b1;
    m_axi.wready = 1'b1;
    m_axi.bvalid = 1'b0;
    m_axi.bresp = 2'b00;
    m_axi.rvalid = 1'b0;
    m_axi.rlast = 1'b0;
    m_axi.rresp = 2'b00;
    m_axi.rdata = '0;
    {s_aw, s_wl, s_bhs, s_ract, s_rhs} = '0;
    s_ra = '0; s_rn = 0; s_ri = 0;
    forever begin
      @(posedge mem_clk); #1;
      if (rst) begin
        m_axi.bvalid = 1'b0;
        m_axi.rvalid = 1'b0;
        m_axi.rlast = 1'b0;
        {s_aw, s_wl, s_bhs, s_ract, s_rhs} = '0;
      end else begin
        if (s_bhs) begin
          m_axi.bvalid = 1'b0;
          s_bhs = 1'b0;
        end else if (s_aw && s_wl && !m_axi.bvalid) begin
          m_axi.bvalid = 1'b1;
          m_axi.bresp = bresp_cfg;
          s_aw = 1'b0;
          s_wl = 1'b0;
        end
        if (s_rhs) begin
          s_ri++;
          s_rhs = 1'b0;
          m_axi.rvalid = 1'b0;
          m_axi.rlast = 1'b0;
        end
        if (s_ract) begin
          if (s_ri < s_rn) begin
            m_axi.rvalid = 1'b1;
            m_axi.rdata = rpat(s_ra, s_ri);
            m_axi.rlast = (s_ri == s_rn - 1);
          end else s_ract = 1'b0;
        end
        m_axi.wready = rand_wready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge mem_clk);
      if (!rst) begin
        if (m_axi.awvalid && m_axi.awready) s_aw = 1'b1;
        if (m_axi.wvalid && m_axi.wready && m_axi.wlast) s_wl = 1'b1;
        if (m_axi.bvalid && m_axi.bready) s_bhs = 1'b1;
        if (m_axi.arvalid && m_axi.arready) begin
          s_ract = 1'b1;
          s_ra = m_axi.araddr;
          s_rn = int'(m_axi.arlen) + 1;
          s_ri = 0;
        end
        if (m_axi.rvalid && m_axi.rready) s_rhs = 1'b1;
      end
    end
  end

  // User write-data source: answers each data_req on the following cycle.
  initial begin
    bit dr;
    forever begin
      @(negedge mem_clk);
      dr = wr_burst_data_req;
      @(posedge mem_clk); #1;
      if (dr) begin
        wr_burst_data = wpat(cur_id, d_i);
        d_i++;
      end
    end
  end

  task automatic tick();
    @(posedge mem_clk); #1;
  endtask

  task automatic set_wr(input logic [31:0] a, input int len);
    m_wr_addr = a & ~32'h7;
    m_wr_len = clamp(len);
    w_idx = 0;
    d_i = 0;
    cur_id = cur_id + 32'd1;
    wr_burst_addr = a;
    wr_burst_len = 10'(len);
  endtask

  task automatic set_rd(input logic [31:0] a, input int len);
    m_rd_addr = a & ~32'h7;
    m_rd_len = clamp(len);
    r_idx = 0;
    rd_burst_addr = a;
    rd_burst_len = 10'(len);
  endtask

  task automatic wait_fin(input bit w, output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 4000) begin
      @(negedge mem_clk);
      cyc++;
      got = w ? wr_burst_finish : rd_burst_finish;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_finish_timeout actual=none required=pulse",
               w ? "wr" : "rd");
    end
  endtask

  task automatic do_wr(input logic [31:0] a, input int len, output int cyc);
    int aw0, dr0, f0;
    aw0 = aw_cnt; dr0 = dreq_cnt; f0 = wfin_cnt;
    set_wr(a, len);
    wr_burst_req = 1'b1;
    wait_fin(1'b1, cyc);
    tick();
    wr_burst_req = 1'b0;
    tick();
    chk("wr_beats", w_idx, m_wr_len);
    chk("wr_data_req_cnt", dreq_cnt - dr0, m_wr_len);
    chk("wr_aw_cnt", aw_cnt - aw0, (m_wr_len > 0) ? 1 : 0);
    chk("wr_finish_cnt", wfin_cnt - f0, 1);
    m_last = "W";
  endtask

  task automatic do_rd(input logic [31:0] a, input int len, output int cyc);
    int ar0, f0;
    ar0 = ar_cnt; f0 = rfin_cnt;
    set_rd(a, len);
    rd_burst_req = 1'b1;
    wait_fin(1'b0, cyc);
    tick();
    rd_burst_req = 1'b0;
    tick();
    chk("rd_beats", r_idx, m_rd_len);
    chk("rd_ar_cnt", ar_cnt - ar0, (m_rd_len > 0) ? 1 : 0);
    chk("rd_finish_cnt", rfin_cnt - f0, 1);
    m_last = "R";
  endtask

  task automatic both_round();
    int c;
    set_wr(32'h0000_1000 + 32'(cur_id) * 32'h100, 4);
    set_rd(32'h0000_2000, 3);
    wr_burst_req = 1'b1;
    rd_burst_req = 1'b1;
    wait_fin(1'b1, c);
    tick();
    wr_burst_req = 1'b0;
    wait_fin(1'b0, c);
    tick();
    rd_burst_req = 1'b0;
    tick();
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_awvalid"}, m_axi.awvalid, 0);
    chk({nm, "_wvalid"}, m_axi.wvalid, 0);
    chk({nm, "_bready"}, m_axi.bready, 0);
    chk({nm, "_arvalid"}, m_axi.arvalid, 0);
    chk({nm, "_rready"}, m_axi.rready, 0);
    chk({nm, "_data_req"}, wr_burst_data_req, 0);
    chk({nm, "_wr_finish"}, wr_burst_finish, 0);
    chk({nm, "_rd_finish"}, rd_burst_finish, 0);
    chk({nm, "_rd_valid"}, rd_burst_data_valid, 0);
    chk({nm, "_axi_error"}, axi_error, 0);
  endtask

  initial begin
    int cyc, n;
    logic [7:0] first, other;
    rst = 1'b1;
    repeat (3) tick();
    @(negedge mem_clk);
    chk_idle("reset");
    tick();
    rst = 1'b0;
    tick();

    // Unaligned 128-beat write, then aligned 128-beat read.
    do_wr(32'h0200_0007, 128, cyc);
    chk("t1_awaddr_lit", last_awaddr, 32'h0200_0000);
    chk("t1_awlen_lit", last_awlen, 127);
    do_rd(32'h0200_0000, 128, cyc);
    chk("t2_arlen_lit", last_arlen, 127);
    chk("t2_beats_lit", r_idx, 128);

    // Simultaneous requests alternate, starting opposite the last served.
    fin_q.delete();
    first = (m_last == "R") ? "W" : "R";
    other = (first == "W") ? "R" : "W";
    both_round();
    both_round();
    m_last = other;
    chk("arb_fin_count", fin_q.size(), 4);
    n = fin_q.size() < 4 ? fin_q.size() : 4;
    for (int k = 0; k < n; k++)
      chk($sformatf("arb_order_%0d", k), fin_q[k], (k % 2 == 0) ? first : other);
    if (n > 0) chk("arb_first_lit", fin_q[0], "W");

    // Random W back-pressure.
    rand_wready = 1'b1;
    do_wr(32'h0300_0010, 16, cyc);
    rand_wready = 1'b0;
    chk("t3_data_req_lit", w_idx, 16);

    // Zero-length requests and clamp.
    do_wr(32'h0000_0400, 0, cyc);
    chk("len0_wr_latency", cyc, 2);
    do_rd(32'h0000_0500, 0, cyc);
    chk("len0_rd_latency", cyc, 2);
    do_wr(32'h0400_0000, 300, cyc);
    chk("clamp_awlen_lit", last_awlen, 255);
    chk("clamp_beats_lit", w_idx, 256);
    do_rd(32'h0500_0008, 300, cyc);
    chk("clamp_arlen_lit", last_arlen, 255);

    // Error response, then reset in the middle of a read.
    bresp_cfg = 2'b10;
    do_wr(32'h0000_0600, 2, cyc);
    bresp_cfg = 2'b00;
    chk("axi_error_set", axi_error, ERR_EN);
    do_wr(32'h0000_0700, 1, cyc);
    chk("axi_error_held", axi_error, ERR_EN);
    set_rd(32'h0000_0800, 128);
    rd_burst_req = 1'b1;
    n = 0;
    while (r_idx < 10 && n < 500) begin
      @(negedge mem_clk);
      n++;
    end
    chk("mid_rd_progress", r_idx >= 10, 1);
    tick();
    rst = 1'b1;
    rd_burst_req = 1'b0;
    tick();
    @(negedge mem_clk);
    chk_idle("mid_rst");
    tick();
    rst = 1'b0;
    tick();
    fin_q.delete();
    both_round();
    chk("post_rst_fin_count", fin_q.size(), 2);
    if (fin_q.size() > 0) chk("post_rst_write_first", fin_q[0], "W");
    m_last = "R";
    do_rd(32'h0000_0900, 4, cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
